multi_sched: RTL and testbench

MULTI_SCHED -- requirements
Module: multi_sched

---
 rtl/multi_sched.sv | 110 +++++++++++
 tb/tb_multi_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sched.sv
// multi_sched: round-robin scheduler sharing one shift-add multiplier among NUM_REQ requesters.
// Optional zero-operand bypass is enabled by defining MULTI_SCHED_ZERO_BYPASS_EN.
module multi_sched #(
  parameter int DATA_WIDTH = 2048,
  parameter int NUM_REQ    = 4,
  parameter int MUL_LAT    = DATA_WIDTH + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  output logic [NUM_REQ-1:0]            req_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat2,
  output logic                          mul_vld,
  output logic [DATA_WIDTH-1:0]         mul_dat1,
  output logic [DATA_WIDTH-1:0]         mul_dat2,
  input  logic [2*DATA_WIDTH-1:0]       mul_product,
  output logic                          rsp_vld,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_product,
  input  logic                          rsp_rdy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MUL_LAT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                  state_q, state_d;
  logic [IW-1:0]           rr_q, rr_d, id_q, id_d, gnt_id, ix;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, op1, op2;
  logic [2*DATA_WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    gnt_ok, xfer, zero_op;
  // Scan from farthest to nearest so the requester nearest rr_q wins.
  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = '0;
    ix     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      ix = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_vld[ix]) begin
        gnt_ok = 1'b1;
        gnt_id = ix;
      end
    end
  end
  assign req_rdy = (state_q == IDLE && !rst && gnt_ok) ? NUM_REQ'(1) << gnt_id : '0;
  assign xfer    = |(req_vld & req_rdy);
  assign op1     = req_dat1[gnt_id*DATA_WIDTH +: DATA_WIDTH];
  assign op2     = req_dat2[gnt_id*DATA_WIDTH +: DATA_WIDTH];
`ifdef MULTI_SCHED_ZERO_BYPASS_EN
  assign zero_op = ~|op1 | ~|op2;
`else
  assign zero_op = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (xfer) begin
        id_d    = gnt_id;
        a_d     = op1;
        b_d     = op2;
        p_d     = zero_op ? '0 : p_q;
        state_d = zero_op ? RESP : ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (cnt_q == CW'(MUL_LAT - 2)) begin
        p_d     = mul_product;
        state_d = RESP;
      end else cnt_d = cnt_q + 1'b1;
      RESP: if (rsp_rdy) begin
        state_d = IDLE;
        rr_d    = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end
  assign mul_vld     = state_q == ISSUE;
  assign mul_dat1    = a_q;
  assign mul_dat2    = b_q;
  assign rsp_vld     = state_q == RESP;
  assign rsp_id      = id_q;
  assign rsp_product = p_q;
endmodule

// File: tb/tb_multi_sched.sv
// tb_multi_sched: directed self-checking bench for multi_sched with a latency-10 multiplier model.
module tb_multi_sched;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int ML = 10;
`ifdef MULTI_SCHED_ZERO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld, req_rdy;
  logic [NR*DW-1:0] req_dat1, req_dat2;
  logic            mul_vld;
  logic [DW-1:0]   mul_dat1, mul_dat2;
  logic [2*DW-1:0] mul_product;
  logic            rsp_vld;
  logic [1:0]      rsp_id;
  logic [2*DW-1:0] rsp_product;
  logic            rsp_rdy;
  int n_cmp = 0;
  int n_err = 0;
  int mul_cnt = 0;
  int id_log[$];
  int pr_log[$];
  logic [3:0]      mcnt = '0;
  logic [DW-1:0]   ma = '0, mb = '0;
  multi_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_dat1(req_dat1), .req_dat2(req_dat2), .mul_vld(mul_vld),
    .mul_dat1(mul_dat1), .mul_dat2(mul_dat2), .mul_product(mul_product),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_rdy(rsp_rdy)
  );
  always #5 clk = ~clk;
  // Product is valid only in the single cycle the scheduler should sample it; garbage otherwise.
  always @(posedge clk) begin
    if (mul_vld) begin
      mcnt <= 4'(ML - 1);
      ma   <= mul_dat1;
      mb   <= mul_dat2;
    end else if (mcnt != 0) mcnt <= mcnt - 1'b1;
  end
  assign mul_product = (mcnt == 1) ? 16'(ma) * 16'(mb) : 16'hA5A5;
  always @(posedge clk) begin
    if (mul_vld) mul_cnt++;
    if (!rst && rsp_vld && rsp_rdy) begin
      id_log.push_back(int'(rsp_id));
      pr_log.push_back(int'(rsp_product));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
    req_dat1[i*DW +: DW] = x;
    req_dat2[i*DW +: DW] = y;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_vld && n < 100) begin
      tick;
      n++;
    end
  endtask
  task automatic chk_log(input string tag, input int ids[5], input int prs[5], input int len);
    chk({tag, "_len"}, 64'(id_log.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      if (i < id_log.size()) begin
        chk($sformatf("%s_id%0d", tag, i), 64'(id_log[i]), 64'(ids[i]));
        chk($sformatf("%s_pr%0d", tag, i), 64'(pr_log[i]), 64'(prs[i]));
      end
    end
  endtask
  initial begin
    int n, m0, seen, guard;
    rst = 1'b1;
    rsp_rdy = 1'b1;
    req_dat1 = '0;
    req_dat2 = '0;
    for (int i = 0; i < NR; i++) set_op(i, DW'(i + 3), DW'(i + 5));
    req_vld = 4'b1111;
    tick;
    tick;
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_mul_vld", 64'(mul_vld), 64'd0);
    chk("rst_dat1", 64'(mul_dat1), 64'd0);
    chk("rst_dat2", 64'(mul_dat2), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_pr", 64'(rsp_product), 64'd0);
    // All four held from reset: strict rotation starting at id 0.
    rst = 1'b0;
    #1;
    chk("cont_first_gnt", 64'(req_rdy), 64'b0001);
    guard = 0;
    while (id_log.size() < 5 && guard < 300) begin
      tick;
      guard++;
    end
    req_vld = '0;
    chk_log("cont", '{0, 1, 2, 3, 0}, '{15, 24, 35, 48, 15}, 5);
    id_log.delete();
    pr_log.delete();
    req_vld = 4'b0100;
    #1;
    chk("solo2_gnt", 64'(req_rdy), 64'b0100);
    tick;
    req_vld = 4'b1010;
    guard = 0;
    while (id_log.size() < 3 && guard < 200) begin
      tick;
      guard++;
    end
    req_vld = '0;
    chk_log("rr231", '{2, 3, 1, 0, 0}, '{35, 48, 24, 0, 0}, 3);
    // Single request 13*11 on id 0 (rr now 2, wraps to 0).
    set_op(0, 8'd13, 8'd11);
    req_vld = 4'b0001;
    m0 = mul_cnt;
    #1;
    chk("single_gnt", 64'(req_rdy), 64'b0001);
    tick;
    req_vld = '0;
    chk("single_mul_vld", 64'(mul_vld), 64'd1);
    chk("single_dat1", 64'(mul_dat1), 64'd13);
    chk("single_dat2", 64'(mul_dat2), 64'd11);
    chk("single_busy_rdy", 64'(req_rdy), 64'd0);
    tick;
    chk("single_mul_pulse", 64'(mul_vld), 64'd0);
    wait_rsp(n);
    chk("single_lat", 64'(n + 1), 64'd10);
    chk("single_id", 64'(rsp_id), 64'd0);
    chk("single_pr", 64'(rsp_product), 64'd143);
    chk("single_mul_cnt", 64'(mul_cnt - m0), 64'd1);
    tick;
    chk("single_rsp_drop", 64'(rsp_vld), 64'd0);
    // Backpressure on id 2 (7*9).
    rsp_rdy = 1'b0;
    set_op(2, 8'd7, 8'd9);
    req_vld = 4'b0100;
    #1;
    chk("bp_gnt", 64'(req_rdy), 64'b0100);
    tick;
    req_vld = '0;
    wait_rsp(n);
    chk("bp_lat", 64'(n), 64'd10);
    req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_vld", 64'(rsp_vld), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd2);
      chk("bp_pr", 64'(rsp_product), 64'd63);
      chk("bp_req_rdy", 64'(req_rdy), 64'd0);
      tick;
    end
    req_vld = '0;
    rsp_rdy = 1'b1;
    tick;
    chk("bp_rsp_drop", 64'(rsp_vld), 64'd0);
    // Zero operand on id 1 (rr now 3, wraps past 0 to 1).
    set_op(1, 8'd0, 8'd255);
    req_vld = 4'b0010;
    m0 = mul_cnt;
    #1;
    chk("zero_gnt", 64'(req_rdy), 64'b0010);
    tick;
    req_vld = '0;
    wait_rsp(n);
    chk("zero_lat", 64'(n), BYP ? 64'd0 : 64'd10);
    chk("zero_id", 64'(rsp_id), 64'd1);
    chk("zero_pr", 64'(rsp_product), 64'd0);
    tick;
    chk("zero_mul_cnt", 64'(mul_cnt - m0), BYP ? 64'd0 : 64'd1);
    // Reset in the middle of WAIT on id 2.
    req_vld = 4'b0100;
    #1;
    chk("abort_gnt", 64'(req_rdy), 64'b0100);
    tick;
    req_vld = '0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("abort_mul_vld", 64'(mul_vld), 64'd0);
    chk("abort_dat1", 64'(mul_dat1), 64'd0);
    chk("abort_dat2", 64'(mul_dat2), 64'd0);
    chk("abort_rsp_id", 64'(rsp_id), 64'd0);
    chk("abort_rsp_pr", 64'(rsp_product), 64'd0);
    id_log.delete();
    pr_log.delete();
    seen = 0;
    repeat (20) begin
      tick;
      if (rsp_vld) seen++;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    chk("abort_no_log", 64'(id_log.size()), 64'd0);
    // rr reset to 0: with 0 and 3 requesting, 0 must win.
    set_op(0, 8'd255, 8'd255);
    req_vld = 4'b1001;
    #1;
    chk("post_gnt", 64'(req_rdy), 64'b0001);
    tick;
    req_vld = '0;
    wait_rsp(n);
    chk("post_lat", 64'(n), 64'd10);
    chk("post_id", 64'(rsp_id), 64'd0);
    chk("post_pr", 64'(rsp_product), 64'd65025);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
